decode_stage: RTL and testbench

Registered RV32I/RV64I instruction decode stage between the fetch unit (IF_*) and the register-read/execute stage (DCR_*). Decodes all nine base opcode groups, zeroes unused fields, and sign-extends immediates to XLEN. Holds up to two decoded instructions behind a valid/ready handshake with flush support, so the pipeline can stall without losing instructions or bubbling.

---
 rtl/decode_stage.sv | 184 ++++++++++++++++++
 tb/tb_decode_stage.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Registered RV32I/RV64I decode stage with a main+skid buffer between fetch and register-read.
// Optional feature: define DCR_ILLEGAL_TRAP_EN to flag unknown opcodes on DCR_illegal instead of issuing a NOP.
module decode_stage #(
  parameter int XLEN = 32,
  parameter int SKID = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            IF_valid,
  output logic            IF_ready,
  input  logic [31:0]     IF_ins,
  input  logic [XLEN-1:0] IF_pc,
  input  logic            flush,
  output logic            DCR_valid,
  input  logic            DCR_ready,
  output logic            DCR_wr_en,
  output logic            DCR_mem_en,
  output logic            DCR_mem_wr,
  output logic            DCR_imm_sel,
  output logic            DCR_branch,
  output logic            DCR_jump,
  output logic [2:0]      DCR_fn_3,
  output logic [4:0]      DCR_rd_sel,
  output logic [4:0]      DCR_rs1_sel,
  output logic [4:0]      DCR_rs2_sel,
  output logic [6:0]      DCR_fn_7,
  output logic [6:0]      DCR_opcode,
  output logic [XLEN-1:0] DCR_imm_val,
  output logic [XLEN-1:0] DCR_pc
`ifdef DCR_ILLEGAL_TRAP_EN
  ,
  output logic            DCR_illegal
`endif
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    logic            wr_en;
    logic            mem_en;
    logic            mem_wr;
    logic            imm_sel;
    logic            branch;
    logic            jump;
    logic [2:0]      fn_3;
    logic [4:0]      rd_sel;
    logic [4:0]      rs1_sel;
    logic [4:0]      rs2_sel;
    logic [6:0]      fn_7;
    logic [6:0]      opcode;
    logic [XLEN-1:0] imm_val;
    logic [XLEN-1:0] pc;
`ifdef DCR_ILLEGAL_TRAP_EN
    logic            illegal;
`endif
  } dec_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  dec_t        dec, main_q, skid_q;
  state_t      state_q, state_d;
  logic        accept, pop, load_main_dec, load_main_skid, load_skid;

  assign imm_i = {{20{IF_ins[31]}}, IF_ins[31:20]};
  assign imm_s = {{20{IF_ins[31]}}, IF_ins[31:25], IF_ins[11:7]};
  assign imm_b = {{19{IF_ins[31]}}, IF_ins[31], IF_ins[7], IF_ins[30:25], IF_ins[11:8], 1'b0};
  assign imm_u = {IF_ins[31:12], 12'h000};
  assign imm_j = {{11{IF_ins[31]}}, IF_ins[31], IF_ins[19:12], IF_ins[20], IF_ins[30:21], 1'b0};

  // NOTE: every field is defaulted first so each opcode arm only sets what its format uses; no latches.
  always_comb begin
    dec        = '0;
    dec.pc     = IF_pc;
    dec.opcode = IF_ins[6:0];
    case (IF_ins[6:0])
      OP_R: begin
        dec.wr_en = 1'b1; dec.fn_3 = IF_ins[14:12]; dec.rd_sel = IF_ins[11:7];
        dec.rs1_sel = IF_ins[19:15]; dec.rs2_sel = IF_ins[24:20]; dec.fn_7 = IF_ins[31:25];
      end
      OP_I, OP_LOAD, OP_JALR: begin
        dec.wr_en = 1'b1; dec.imm_sel = 1'b1; dec.fn_3 = IF_ins[14:12];
        dec.rd_sel = IF_ins[11:7]; dec.rs1_sel = IF_ins[19:15]; dec.imm_val = sext(imm_i);
        dec.mem_en = (IF_ins[6:0] == OP_LOAD);
        dec.jump   = (IF_ins[6:0] == OP_JALR);
      end
      OP_STORE: begin
        dec.mem_en = 1'b1; dec.mem_wr = 1'b1; dec.imm_sel = 1'b1; dec.fn_3 = IF_ins[14:12];
        dec.rs1_sel = IF_ins[19:15]; dec.rs2_sel = IF_ins[24:20]; dec.imm_val = sext(imm_s);
      end
      OP_BRANCH: begin
        dec.branch = 1'b1; dec.imm_sel = 1'b1; dec.fn_3 = IF_ins[14:12];
        dec.rs1_sel = IF_ins[19:15]; dec.rs2_sel = IF_ins[24:20]; dec.imm_val = sext(imm_b);
      end
      OP_LUI, OP_AUIPC: begin
        dec.wr_en = 1'b1; dec.imm_sel = 1'b1; dec.rd_sel = IF_ins[11:7]; dec.imm_val = sext(imm_u);
      end
      OP_JAL: begin
        dec.wr_en = 1'b1; dec.imm_sel = 1'b1; dec.jump = 1'b1;
        dec.rd_sel = IF_ins[11:7]; dec.imm_val = sext(imm_j);
      end
      default: begin
`ifdef DCR_ILLEGAL_TRAP_EN
        dec.illegal = 1'b1;
`else
        dec.opcode = OP_I;
`endif
      end
    endcase
  end

  assign DCR_valid = (state_q != EMPTY);
  assign IF_ready  = rst_n && ((SKID != 0) ? (state_q != TWO) : (state_q == EMPTY || DCR_ready));
  assign accept    = IF_valid && IF_ready && !flush;
  assign pop       = DCR_valid && DCR_ready;

  always_comb begin
    state_d        = state_q;
    load_main_dec  = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin state_d = ONE; load_main_dec = 1'b1; end
        ONE: begin
          if (accept && pop)  load_main_dec = 1'b1;
          else if (accept)    begin state_d = TWO; load_skid = 1'b1; end
          else if (pop)       state_d = EMPTY;
        end
        TWO:     if (pop) begin state_d = ONE; load_main_skid = 1'b1; end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load_main_dec)       main_q <= dec;
      else if (load_main_skid) main_q <= skid_q;
    end
  end

  // NOTE: skid data is never visible unless the TWO state says it is valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (load_skid) skid_q <= dec;
  end

  assign DCR_wr_en   = main_q.wr_en;
  assign DCR_mem_en  = main_q.mem_en;
  assign DCR_mem_wr  = main_q.mem_wr;
  assign DCR_imm_sel = main_q.imm_sel;
  assign DCR_branch  = main_q.branch;
  assign DCR_jump    = main_q.jump;
  assign DCR_fn_3    = main_q.fn_3;
  assign DCR_rd_sel  = main_q.rd_sel;
  assign DCR_rs1_sel = main_q.rs1_sel;
  assign DCR_rs2_sel = main_q.rs2_sel;
  assign DCR_fn_7    = main_q.fn_7;
  assign DCR_opcode  = main_q.opcode;
  assign DCR_imm_val = main_q.imm_val;
  assign DCR_pc      = main_q.pc;
`ifdef DCR_ILLEGAL_TRAP_EN
  assign DCR_illegal = main_q.illegal;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Table-driven bench for decode_stage (XLEN=32, SKID=1) with an in-order scoreboard queue.
module tb_decode_stage;

  logic        clk = 1'b0, rst_n = 1'b0, IF_valid = 1'b0, flush = 1'b0, DCR_ready = 1'b0;
  logic        IF_ready, DCR_valid;
  logic [31:0] IF_ins = '0, IF_pc = '0;
  logic        DCR_wr_en, DCR_mem_en, DCR_mem_wr, DCR_imm_sel, DCR_branch, DCR_jump;
  logic [2:0]  DCR_fn_3;
  logic [4:0]  DCR_rd_sel, DCR_rs1_sel, DCR_rs2_sel;
  logic [6:0]  DCR_fn_7, DCR_opcode;
  logic [31:0] DCR_imm_val, DCR_pc;
  logic        ill_out;

`ifdef DCR_ILLEGAL_TRAP_EN
  logic DCR_illegal;
  assign ill_out = DCR_illegal;
`else
  assign ill_out = 1'b0;
`endif

  decode_stage #(.XLEN(32), .SKID(1)) dut (
    .clk(clk), .rst_n(rst_n), .IF_valid(IF_valid), .IF_ready(IF_ready), .IF_ins(IF_ins),
    .IF_pc(IF_pc), .flush(flush), .DCR_valid(DCR_valid), .DCR_ready(DCR_ready),
    .DCR_wr_en(DCR_wr_en), .DCR_mem_en(DCR_mem_en), .DCR_mem_wr(DCR_mem_wr),
    .DCR_imm_sel(DCR_imm_sel), .DCR_branch(DCR_branch), .DCR_jump(DCR_jump),
    .DCR_fn_3(DCR_fn_3), .DCR_rd_sel(DCR_rd_sel), .DCR_rs1_sel(DCR_rs1_sel),
    .DCR_rs2_sel(DCR_rs2_sel), .DCR_fn_7(DCR_fn_7), .DCR_opcode(DCR_opcode),
    .DCR_imm_val(DCR_imm_val), .DCR_pc(DCR_pc)
`ifdef DCR_ILLEGAL_TRAP_EN
    , .DCR_illegal(DCR_illegal)
`endif
  );

  always #5 clk = ~clk;

  // ctrl order: {wr_en, mem_en, mem_wr, imm_sel, branch, jump}
  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [5:0]  ctrl;
    logic [2:0]  fn3;
    logic [4:0]  rd, rs1, rs2;
    logic [6:0]  fn7, opc;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  vec_t tbl[13];
  vec_t sbq[$];
  vec_t cur;
  int   checks = 0, errors = 0, pops = 0;

  function automatic vec_t mk(logic [31:0] ins, int idx, logic [5:0] ctrl, logic [2:0] fn3,
                              logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2, logic [6:0] fn7,
                              logic [6:0] opc, logic [31:0] imm, logic ill);
    vec_t v;
    v.ins = ins; v.pc = 32'h0000_1000 + 32'(idx * 4); v.ctrl = ctrl; v.fn3 = fn3;
    v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.fn7 = fn7; v.opc = opc; v.imm = imm; v.ill = ill;
    return v;
  endfunction

  function automatic logic [102:0] pack_exp(vec_t v);
    return {v.ctrl, v.fn3, v.rd, v.rs1, v.rs2, v.fn7, v.opc, v.imm, v.pc, v.ill};
  endfunction

  function automatic logic [102:0] pack_act();
    return {DCR_wr_en, DCR_mem_en, DCR_mem_wr, DCR_imm_sel, DCR_branch, DCR_jump, DCR_fn_3,
            DCR_rd_sel, DCR_rs1_sel, DCR_rs2_sel, DCR_fn_7, DCR_opcode, DCR_imm_val, DCR_pc, ill_out};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int idx);
    cur    = tbl[idx];
    IF_ins = cur.ins;
    IF_pc  = cur.pc;
  endtask

  // Starts at a falling edge with inputs set; scores the handshakes of the coming rising edge.
  task automatic step(input bit rand_rdy, output bit acc);
    if (rand_rdy) DCR_ready = 1'($urandom_range(0, 1));
    #1;
    acc = IF_valid && IF_ready && !flush && rst_n;
    if (DCR_valid && DCR_ready && rst_n) begin
      if (sbq.size() == 0) begin
        check("unexpected_output", 128'(DCR_valid), 128'(0));
      end else begin
        vec_t e;
        e = sbq.pop_front();
        pops++;
        check($sformatf("dcr_out_%08h", e.ins), 128'(pack_act()), 128'(pack_exp(e)));
      end
    end
    if (acc) sbq.push_back(cur);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic feed(input int idx, input bit rand_rdy, output int tries);
    bit acc;
    acc   = 1'b0;
    tries = 0;
    drive(idx);
    IF_valid = 1'b1;
    for (int t = 0; t < 40 && !acc; t++) begin
      step(rand_rdy, acc);
      tries++;
    end
    if (!acc) check("accept_timeout", 128'(acc), 128'(1));
    IF_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    IF_valid  = 1'b0;
    DCR_ready = 1'b1;
    for (int i = 0; i < 50 && sbq.size() > 0; i++) step(1'b0, acc);
    check("drain_left", 128'(sbq.size()), 128'(0));
    check("drain_valid", 128'(DCR_valid), 128'(0));
  endtask

  initial begin
    bit acc;
    int tries, total, k, pops0;

    tbl[0]  = mk(32'hFFF00093, 0,  6'b100100, 3'd0, 5'd1,  5'd0,  5'd0, 7'h00, 7'h13, 32'hFFFFFFFF, 1'b0);
    tbl[1]  = mk(32'h00112623, 1,  6'b011100, 3'd2, 5'd0,  5'd2,  5'd1, 7'h00, 7'h23, 32'h0000000C, 1'b0);
    tbl[2]  = mk(32'hFE000EE3, 2,  6'b000110, 3'd0, 5'd0,  5'd0,  5'd0, 7'h00, 7'h63, 32'hFFFFFFFC, 1'b0);
    tbl[3]  = mk(32'h123452B7, 3,  6'b100100, 3'd0, 5'd5,  5'd0,  5'd0, 7'h00, 7'h37, 32'h12345000, 1'b0);
    tbl[4]  = mk(32'h402081B3, 4,  6'b100000, 3'd0, 5'd3,  5'd1,  5'd2, 7'h20, 7'h33, 32'h00000000, 1'b0);
    tbl[5]  = mk(32'hFF83A303, 5,  6'b110100, 3'd2, 5'd6,  5'd7,  5'd0, 7'h00, 7'h03, 32'hFFFFFFF8, 1'b0);
    tbl[6]  = mk(32'hFFFFF0EF, 6,  6'b100101, 3'd0, 5'd1,  5'd0,  5'd0, 7'h00, 7'h6F, 32'hFFFFFFFE, 1'b0);
    tbl[7]  = mk(32'h004280E7, 7,  6'b100101, 3'd0, 5'd1,  5'd5,  5'd0, 7'h00, 7'h67, 32'h00000004, 1'b0);
    tbl[8]  = mk(32'h80000517, 8,  6'b100100, 3'd0, 5'd10, 5'd0,  5'd0, 7'h00, 7'h17, 32'h80000000, 1'b0);
    tbl[9]  = mk(32'hFE320FA3, 9,  6'b011100, 3'd0, 5'd0,  5'd4,  5'd3, 7'h00, 7'h23, 32'hFFFFFFFF, 1'b0);
`ifdef DCR_ILLEGAL_TRAP_EN
    tbl[10] = mk(32'h0000007F, 10, 6'b000000, 3'd0, 5'd0,  5'd0,  5'd0, 7'h00, 7'h7F, 32'h00000000, 1'b1);
`else
    tbl[10] = mk(32'h0000007F, 10, 6'b000000, 3'd0, 5'd0,  5'd0,  5'd0, 7'h00, 7'h13, 32'h00000000, 1'b0);
`endif
    tbl[11] = mk(32'h4030D093, 11, 6'b100100, 3'd5, 5'd1,  5'd1,  5'd0, 7'h00, 7'h13, 32'h00000403, 1'b0);
    tbl[12] = mk(32'h00209863, 12, 6'b000110, 3'd1, 5'd0,  5'd1,  5'd2, 7'h00, 7'h63, 32'h00000010, 1'b0);

    // Reset for two cycles, then the first cycle out of reset.
    @(negedge clk);
    #1 check("if_ready_in_reset", 128'(IF_ready), 128'(0));
    @(negedge clk);
    check("valid_after_reset", 128'(DCR_valid), 128'(0));
    check("outputs_after_reset", 128'(pack_act()), 128'(0));
    rst_n = 1'b1;
    #1 check("if_ready_after_reset", 128'(IF_ready), 128'(1));

    // Single instruction, one-cycle latency.
    DCR_ready = 1'b0;
    drive(0);
    IF_valid = 1'b1;
    step(1'b0, acc);
    IF_valid = 1'b0;
    check("latency_valid", 128'(DCR_valid), 128'(1));
    drain();

    // Full table at full throughput.
    DCR_ready = 1'b1;
    total = 0;
    for (int i = 0; i < 13; i++) begin
      feed(i, 1'b0, tries);
      total += tries;
    end
    check("throughput_cycles", 128'(total), 128'(13));
    drain();

    // Random ready and valid gaps.
    for (int rep = 0; rep < 3; rep++) begin
      for (int i = 0; i < 13; i++) begin
        if ($urandom_range(0, 2) == 0) step(1'b1, acc);
        feed(i, 1'b1, tries);
      end
    end
    drain();

    // Stall: four offered, two held, then released in order.
    DCR_ready = 1'b0;
    k = 0;
    pops0 = pops;
    for (int c = 0; c < 4; c++) begin
      drive(1 + k);
      IF_valid = 1'b1;
      step(1'b0, acc);
      if (acc) k++;
    end
    IF_valid = 1'b0;
    check("stall_accepted", 128'(k), 128'(2));
    #1 check("stall_if_ready", 128'(IF_ready), 128'(0));
    check("stall_valid", 128'(DCR_valid), 128'(1));
    DCR_ready = 1'b1;
    while (k < 4) begin
      feed(1 + k, 1'b0, tries);
      k++;
    end
    drain();
    check("stall_pops", 128'(pops - pops0), 128'(4));

    // Flush while holding two with fetch offering; a second flush accepts nothing either.
    DCR_ready = 1'b0;
    feed(5, 1'b0, tries);
    feed(6, 1'b0, tries);
    drive(7);
    IF_valid = 1'b1;
    flush = 1'b1;
    step(1'b0, acc);
    sbq.delete();
    check("flush_valid", 128'(DCR_valid), 128'(0));
    check("flush_if_ready", 128'(IF_ready), 128'(1));
    step(1'b0, acc);
    check("flush2_valid", 128'(DCR_valid), 128'(0));
    check("flush2_if_ready", 128'(IF_ready), 128'(1));
    flush = 1'b0;
    IF_valid = 1'b0;
    step(1'b0, acc);
    check("flushed_never_appears", 128'(DCR_valid), 128'(0));
    DCR_ready = 1'b1;
    feed(8, 1'b0, tries);
    drain();

    // Flush coinciding with a downstream handshake still delivers that instruction.
    DCR_ready = 1'b0;
    feed(9, 1'b0, tries);
    DCR_ready = 1'b1;
    flush = 1'b1;
    pops0 = pops;
    step(1'b0, acc);
    flush = 1'b0;
    check("flush_pop_done", 128'(pops - pops0), 128'(1));
    check("flush_pop_valid", 128'(DCR_valid), 128'(0));

    // Reset during a two-entry stall.
    DCR_ready = 1'b0;
    feed(11, 1'b0, tries);
    feed(12, 1'b0, tries);
    check("pre_reset_full", 128'(IF_ready), 128'(0));
    rst_n = 1'b0;
    drive(0);
    IF_valid = 1'b1;
    #1 check("if_ready_mid_reset", 128'(IF_ready), 128'(0));
    step(1'b0, acc);
    sbq.delete();
    rst_n = 1'b1;
    IF_valid = 1'b0;
    check("reset_stall_valid", 128'(DCR_valid), 128'(0));
    check("reset_stall_outputs", 128'(pack_act()), 128'(0));
    #1 check("reset_stall_if_ready", 128'(IF_ready), 128'(1));
    feed(3, 1'b0, tries);
    check("post_reset_latency", 128'(DCR_valid), 128'(1));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
